// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO round-robin write arbiter.
package fifo_arb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_t;

   localparam int DEFAULT_WIDTH     = 32;
   localparam int DEFAULT_MAX_BURST = 8;

   function automatic int idx_w(input int n);
      return $clog2(n);
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating priority encoder: picks the first requester after `last`, wrapping around.
module rr_pick
   import fifo_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = idx_w(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   last,
   output logic               any,
   output logic [IDX_W-1:0]   winner
);

   always_comb begin
      int   idx;
      logic found;
      idx    = 0;
      found  = 1'b0;
      winner = '0;
      // last itself is scanned last, so a lone requester can win again
      for (int i = 1; i <= NUM_REQ; i++) begin
         idx = (int'(last) + i) % NUM_REQ;
         if (!found && req[IDX_W'(idx)]) begin
            found  = 1'b1;
            winner = IDX_W'(idx);
         end
      end
   end

   assign any = |req;

endmodule

// File: rtl/fifo_rr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ stream producers.
// Optional FIFO_ARB_PKT_LOCK_EN: hold each grant until the end of the packet.
module fifo_rr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int  NUM_REQ   = 4,
   parameter int  WIDTH     = DEFAULT_WIDTH,
   parameter int  MAX_BURST = DEFAULT_MAX_BURST,
   parameter int  SPACE_W   = 16,
   localparam int IDX_W     = idx_w(NUM_REQ)
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       clear,
   input  logic [NUM_REQ*WIDTH-1:0]   s_tdata,
   input  logic [NUM_REQ-1:0]         s_tvalid,
   input  logic [NUM_REQ-1:0]         s_tlast,
   output logic [NUM_REQ-1:0]         s_tready,
   output logic [WIDTH-1:0]           m_tdata,
   output logic                       m_tvalid,
   input  logic                       m_tready,
   input  logic [SPACE_W-1:0]         fifo_space,
   output logic [IDX_W-1:0]           m_src,
   output logic                       busy
);

   localparam int                 CNT_W     = $clog2(MAX_BURST + 1);
   localparam logic [SPACE_W-1:0] SPACE_MIN = SPACE_W'(MAX_BURST);
   localparam logic [CNT_W-1:0]   CNT_MAX   = CNT_W'(MAX_BURST);
   localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(MAX_BURST - 1);
   localparam logic [IDX_W-1:0]   LAST_INIT = IDX_W'(NUM_REQ - 1);

   arb_state_t       state;
   arb_state_t       state_nxt;
   logic [IDX_W-1:0] last_q;
   logic [CNT_W-1:0] beat_cnt;
   logic [IDX_W-1:0] winner;
   logic             any_req;
   logic             eligible;
   logic             granted;
   logic             src_valid;
   logic             src_last;
   logic             beat;
   logic             release_grant;

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_pick (
      .req    (s_tvalid),
      .last   (last_q),
      .any    (any_req),
      .winner (winner)
   );

   // Admit only when a full burst is guaranteed to fit in the FIFO
   assign eligible  = any_req && (fifo_space >= SPACE_MIN);
   assign src_valid = s_tvalid[m_src];
   assign src_last  = s_tlast[m_src];
   // A clear/reset cycle must not move data, so it masks the grant immediately
   assign granted   = (state == GRANT) && !clear && !reset;
   assign beat      = granted && src_valid && m_tready;

`ifdef FIFO_ARB_PKT_LOCK_EN
   assign release_grant = beat && src_last;
`else
   assign release_grant = !src_valid || (beat && (src_last || beat_cnt == CNT_LAST));
`endif

   always_ff @(posedge clock) begin
      if (reset || clear) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (eligible) state_nxt = GRANT;
         GRANT:   if (release_grant) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset || clear) begin
         m_src    <= '0;
         last_q   <= LAST_INIT;
         beat_cnt <= '0;
      end else begin
         if (state == IDLE && eligible) begin
            m_src <= winner;
         end
         if (state == GRANT) begin
            if (release_grant) begin
               last_q   <= m_src;
               beat_cnt <= '0;
            end else if (beat && beat_cnt != CNT_MAX) begin
               beat_cnt <= beat_cnt + CNT_W'(1);
            end
         end
      end
   end

   always_comb begin
      s_tready = '0;
      m_tdata  = '0;
      m_tvalid = 1'b0;
      busy     = (state == GRANT);
      if (granted) begin
         m_tdata         = s_tdata[int'(m_src)*WIDTH +: WIDTH];
         m_tvalid        = src_valid;
         s_tready[m_src] = m_tready;
      end
   end

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Scoreboard bench for fifo_rr_arbiter: queued producers, a FIFO sink and a burst-level reference model.
`timescale 1ns/1ps
module tb_fifo_rr_arbiter;

   localparam int NUM_REQ   = 4;
   localparam int WIDTH     = 32;
   localparam int MAX_BURST = 8;
   localparam int SPACE_W   = 16;
   localparam int IDX_W     = 2;
   localparam int DEPTH     = 512;
`ifdef FIFO_ARB_PKT_LOCK_EN
   localparam bit LOCK = 1'b1;
`else
   localparam bit LOCK = 1'b0;
`endif

   typedef struct {
      logic [WIDTH-1:0] data;
      logic             last;
   } beat_t;

   typedef struct {
      int               src;
      logic [WIDTH-1:0] data;
   } exp_t;

   logic                     clock = 1'b0;
   logic                     reset = 1'b1;
   logic                     clear = 1'b0;
   logic [NUM_REQ*WIDTH-1:0] s_tdata;
   logic [NUM_REQ-1:0]       s_tvalid;
   logic [NUM_REQ-1:0]       s_tlast;
   logic [NUM_REQ-1:0]       s_tready;
   logic [WIDTH-1:0]         m_tdata;
   logic                     m_tvalid;
   logic                     m_tready;
   logic [SPACE_W-1:0]       fifo_space;
   logic [IDX_W-1:0]         m_src;
   logic                     busy;

   beat_t            pq[NUM_REQ][$];
   exp_t             exp_q[$];
   logic [WIDTH-1:0] fifo_q[$];
   int               beat_cyc[$];
   int               fifo_cnt   = 0;
   int               cyc        = 0;
   int               checks     = 0;
   int               failures   = 0;
   int               model_last = NUM_REQ - 1;
   logic             stall      = 1'b0;
   logic             ovr_en     = 1'b0;
   logic [SPACE_W-1:0] ovr_val  = '0;
   logic [NUM_REQ-1:0] fire;
   logic [NUM_REQ-1:0] src_oh;
   exp_t             mon_e;

   always #5 clock = ~clock;

   assign m_tready   = !stall;
   assign fifo_space = ovr_en ? ovr_val : SPACE_W'(DEPTH - fifo_cnt);

   fifo_rr_arbiter #(
      .NUM_REQ   (NUM_REQ),
      .WIDTH     (WIDTH),
      .MAX_BURST (MAX_BURST),
      .SPACE_W   (SPACE_W)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .clear      (clear),
      .s_tdata    (s_tdata),
      .s_tvalid   (s_tvalid),
      .s_tlast    (s_tlast),
      .s_tready   (s_tready),
      .m_tdata    (m_tdata),
      .m_tvalid   (m_tvalid),
      .m_tready   (m_tready),
      .fifo_space (fifo_space),
      .m_src      (m_src),
      .busy       (busy)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
      end
   endtask

   function automatic logic [WIDTH-1:0] dat(input int ph, input int k, input int j);
      return {8'(ph), 8'(k), 16'(j)};
   endfunction

   task automatic push(input int k, input logic [WIDTH-1:0] d, input bit l);
      beat_t b;
      b.data = d;
      b.last = l;
      pq[k].push_back(b);
   endtask

   task automatic expect_beat(input int k, input logic [WIDTH-1:0] d);
      exp_t e;
      e.src  = k;
      e.data = d;
      exp_q.push_back(e);
   endtask

   // Burst-level model: grant the next non-empty queue after the last winner, take beats until
   // end of packet, burst limit or the queue runs dry (in packet-lock mode only end of packet).
   task automatic plan();
      beat_t lq[NUM_REQ][$];
      beat_t b;
      int    w;
      int    n;
      bit    done;
      for (int k = 0; k < NUM_REQ; k++) lq[k] = pq[k];
      while (1) begin
         w = -1;
         for (int i = 1; i <= NUM_REQ; i++)
            if (w < 0 && lq[(model_last + i) % NUM_REQ].size() > 0) w = (model_last + i) % NUM_REQ;
         if (w < 0) break;
         n    = 0;
         done = 1'b0;
         while (!done) begin
            b = lq[w].pop_front();
            expect_beat(w, b.data);
            n++;
            if (LOCK) done = b.last || lq[w].size() == 0;
            else      done = b.last || n == MAX_BURST || lq[w].size() == 0;
         end
         model_last = w;
      end
   endtask

   task automatic clear_sink();
      fifo_q.delete();
      beat_cyc.delete();
      fifo_cnt = 0;
   endtask

   task automatic wait_drain(input int budget, input bit rand_stall);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         @(posedge clock); #2;
         if (rand_stall) stall = ($urandom_range(0, 3) == 0);
         n++;
      end
      stall = 1'b0;
      if (exp_q.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL drain_timeout: %0d beats outstanding, required 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic wait_beats(input int n, input int budget);
      int t;
      t = 0;
      do begin
         @(posedge clock); #2;
         t++;
      end while (fifo_q.size() < n && t < budget);
      if (fifo_q.size() < n) begin
         checks++;
         failures++;
         $display("FAIL beat_wait: saw %0d beats, required %0d", fifo_q.size(), n);
      end
   endtask

   task automatic settle(input int n);
      repeat (n) @(posedge clock);
      #2;
   endtask

   // Producers: present the queue head, pop it after a handshake seen before the edge
   always begin
      @(negedge clock);
      for (int k = 0; k < NUM_REQ; k++) fire[k] = s_tvalid[k] && s_tready[k];
      @(posedge clock); #1;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (fire[k] === 1'b1 && pq[k].size() > 0) void'(pq[k].pop_front());
         if (pq[k].size() > 0) begin
            s_tvalid[k]                = 1'b1;
            s_tdata[k*WIDTH +: WIDTH]  = pq[k][0].data;
            s_tlast[k]                 = pq[k][0].last;
         end else begin
            s_tvalid[k]                = 1'b0;
            s_tdata[k*WIDTH +: WIDTH]  = '0;
            s_tlast[k]                 = 1'b0;
         end
      end
   end

   // Monitor: FIFO-side sink plus scoreboard pop on every accepted beat
   always @(negedge clock) begin
      if (!reset) begin
         cyc++;
         if (m_tvalid && m_tready) begin
            beat_cyc.push_back(cyc);
            fifo_q.push_back(m_tdata);
            fifo_cnt++;
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_beat: src=%0d data=0x%0h, required no beat", m_src, m_tdata);
            end else begin
               mon_e = exp_q.pop_front();
               check("beat_src", 64'(m_src), 64'(mon_e.src));
               check("beat_data", 64'(m_tdata), 64'(mon_e.data));
            end
         end
         src_oh        = '0;
         src_oh[m_src] = 1'b1;
         check("s_tready_only_granted", 64'(s_tready & ~src_oh), 64'(0));
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: time limit reached before summary");
      $fatal(1);
   end

   initial begin
      int run;
      int len;
      s_tvalid = '0;
      s_tdata  = '0;
      s_tlast  = '0;
      run      = LOCK ? 12 : MAX_BURST;

      // All four stream continuously from reset
      for (int k = 0; k < NUM_REQ; k++)
         for (int j = 0; j < 12; j++) push(k, dat(1, k, j), LOCK && j == 11);
      plan();
      repeat (3) @(posedge clock);
      @(negedge clock);
      check("rst_busy", 64'(busy), 64'(0));
      check("rst_s_tready", 64'(s_tready), 64'(0));
      check("rst_m_tvalid", 64'(m_tvalid), 64'(0));
      check("rst_m_tdata", 64'(m_tdata), 64'(0));
      check("rst_m_src", 64'(m_src), 64'(0));
      @(posedge clock); #2;
      reset = 1'b0;
      @(negedge clock);
      check("c1_busy", 64'(busy), 64'(0));
      check("c1_s_tready", 64'(s_tready), 64'(0));
      @(negedge clock);
      check("c2_m_src", 64'(m_src), 64'(0));
      check("c2_s_tready", 64'(s_tready), 64'(4'b0001));
      check("c2_busy", 64'(busy), 64'(1));
      wait_drain(400, 1'b0);
      check("rr_total_beats", 64'(fifo_q.size()), 64'(48));
      check("rr_burst_back_to_back", 64'(beat_cyc[run-1] - beat_cyc[0]), 64'(run - 1));
      check("rr_one_bubble", 64'(beat_cyc[run] - beat_cyc[run-1]), 64'(2));
      settle(3);

      // Single short packet from req2
      clear_sink();
      push(2, dat(3, 2, 0), 1'b0);
      push(2, dat(3, 2, 1), 1'b0);
      push(2, dat(3, 2, 2), 1'b1);
      plan();
      wait_drain(100, 1'b0);
      @(negedge clock);
      check("pkt_busy_falls", 64'(busy), 64'(0));
      check("pkt_fifo_count", 64'(fifo_q.size()), 64'(3));
      for (int j = 0; j < 3; j++) check("pkt_fifo_readback", 64'(fifo_q[j]), 64'(dat(3, 2, j)));
      settle(3);

      // Admission held off by insufficient FIFO space
      clear_sink();
      ovr_en  = 1'b1;
      ovr_val = SPACE_W'(MAX_BURST - 1);
      for (int j = 0; j < 3; j++) push(1, dat(4, 1, j), j == 2);
      plan();
      repeat (10) begin
         @(negedge clock);
         check("space_hold_busy", 64'(busy), 64'(0));
      end
      @(posedge clock); #2;
      ovr_val = SPACE_W'(MAX_BURST);
      @(negedge clock);
      @(negedge clock);
      check("space_grant_busy", 64'(busy), 64'(1));
      check("space_grant_src", 64'(m_src), 64'(1));
      wait_drain(100, 1'b0);
      ovr_en = 1'b0;
      settle(3);

      // Back-pressure mid-burst
      clear_sink();
      for (int j = 0; j < 10; j++) push(0, dat(5, 0, j), LOCK && j == 9);
      plan();
      wait_beats(3, 100);
      stall = 1'b1;
      repeat (3) begin
         @(negedge clock);
         check("stall_data_held", 64'(m_tdata), 64'(dat(5, 0, 3)));
         check("stall_valid_held", 64'(m_tvalid), 64'(1));
      end
      @(posedge clock); #2;
      stall = 1'b0;
      wait_drain(200, 1'b0);
      check("stall_gap", 64'(beat_cyc[3] - beat_cyc[2]), 64'(4));
      check("stall_burst_len", 64'(beat_cyc[8] - beat_cyc[7]), 64'(LOCK ? 1 : 2));
      settle(3);

      // Clear mid-burst truncates the grant and restarts priority at req0
      clear_sink();
      for (int j = 0; j < 6; j++) push(1, dat(6, 1, j), LOCK && j == 5);
      push(0, dat(6, 0, 0), 1'b0);
      push(0, dat(6, 0, 1), 1'b1);
      expect_beat(1, dat(6, 1, 0));
      expect_beat(1, dat(6, 1, 1));
      expect_beat(0, dat(6, 0, 0));
      expect_beat(0, dat(6, 0, 1));
      for (int j = 2; j < 6; j++) expect_beat(1, dat(6, 1, j));
      model_last = 1;
      wait_beats(2, 100);
      clear = 1'b1;
      @(posedge clock); #2;
      clear = 1'b0;
      @(negedge clock);
      check("clear_s_tready", 64'(s_tready), 64'(0));
      check("clear_busy", 64'(busy), 64'(0));
      @(negedge clock);
      check("clear_next_src", 64'(m_src), 64'(0));
      check("clear_next_busy", 64'(busy), 64'(1));
      wait_drain(200, 1'b0);
      check("clear_gap", 64'(beat_cyc[2] - beat_cyc[1]), 64'(3));
      settle(3);

      // Long packet from req1 while req0 waits
      clear_sink();
      if (LOCK) begin
         for (int j = 0; j < 20; j++) expect_beat(1, dat(7, 1, j));
         expect_beat(0, dat(7, 0, 0));
         expect_beat(0, dat(7, 0, 1));
         model_last = 0;
      end else begin
         for (int j = 0; j < 8; j++) expect_beat(1, dat(7, 1, j));
         expect_beat(0, dat(7, 0, 0));
         expect_beat(0, dat(7, 0, 1));
         for (int j = 8; j < 20; j++) expect_beat(1, dat(7, 1, j));
         model_last = 1;
      end
      for (int j = 0; j < 20; j++) push(1, dat(7, 1, j), j == 19);
      wait_beats(1, 100);
      push(0, dat(7, 0, 0), 1'b0);
      push(0, dat(7, 0, 1), 1'b1);
      wait_drain(300, 1'b0);
      check("long_pkt_total", 64'(fifo_q.size()), 64'(22));
      settle(3);

      // Randomized traffic with random back-pressure
      for (int ph = 10; ph < 16; ph++) begin
         clear_sink();
         for (int k = 0; k < NUM_REQ; k++) begin
            if ($urandom_range(0, 1) == 1) begin
               len = $urandom_range(1, 20);
               for (int j = 0; j < len; j++)
                  push(k, dat(ph, k, j) ^ {$urandom_range(0, 255), 16'h0} & 32'h0000_0000 | dat(ph, k, j),
                       ($urandom_range(0, 4) == 0) || (LOCK && j == len - 1));
            end
         end
         plan();
         wait_drain(3000, 1'b1);
         settle(3);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
